// File: rtl/store_lane_packer.sv
// -----------------------------------------------------------------------------
// store_lane_packer
//
// Store-path narrowing unit for the multi-cycle MIPS core. It accepts a 32-bit
// register value, a store size (SB/SH/SW) and a byte address from the datapath.
// It places the valid bytes on the correct lanes of a little-endian 32-bit
// memory word, generates byte enables, and runs a req/ack write to data memory.
//
// Optional feature macro: MISALIGN_SPLIT_EN
//   defined   - stores that cross a word boundary are issued as two aligned
//               beats (BEAT1 then BEAT2), and a single done follows the last ack.
//   undefined - misaligned halfwords (addr[0] = 1) and misaligned words
//               (addr[1:0] != 0) are rejected with err. No BEAT2 path is built.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   st_valid/st_ready store request from the datapath / unit idle
//   st_size           00 byte, 01 half, 10 word, 11 reserved (always rejected)
//   st_addr, st_data  byte address and register value
//   mem_req/mem_ack   write request to data memory / memory accepted the beat
//   mem_addr          word-aligned beat address
//   mem_wdata         lane-placed write data (the same on both beats)
//   mem_be            byte enables, where bit i covers bits [8i+7:8i]
//   done, err         one-cycle completion / rejection pulses
//   dbg_state_o       current FSM state, for observation only
//
// Handshakes
//   The datapath side is accepted on any rising edge where st_valid && st_ready.
//   The inputs are captured at that edge and are ignored afterwards.
//   On the memory side, mem_req and its addr/wdata/be stay stable until mem_ack
//   is sampled high at a rising edge. mem_ack is ignored while mem_req is low.
// -----------------------------------------------------------------------------
module store_lane_packer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef MISALIGN_SPLIT_EN
  // These are the byte enables of the second word. They are nonzero only for
  // a store that crosses a word boundary.
  logic [3:0]          hi_be_q, hi_be_d;
`endif

  // Lane placement, computed from the live inputs. It is used only on the
  // accept edge.
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [7:0]  lanes8;
  logic [31:0] rot_data;
  logic        reject;

  assign off = st_addr[1:0];

  always_comb begin
    mask = 4'b0000;
    case (st_size)
      SIZE_BYTE: mask = 4'b0001;
      SIZE_HALF: mask = 4'b0011;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
  end

  // Shifting over 8 bits lets the enables that spill past lane 3 land in the
  // upper nibble. Those bits are the lanes of the next word.
  assign lanes8 = {4'b0000, mask} << off;

  // A rotate, rather than a shift, keeps the spilled bytes in the low lanes.
  // The second beat can then reuse the same data word.
  always_comb begin
    rot_data = st_data;
    case (off)
      2'd0:    rot_data = st_data;
      2'd1:    rot_data = {st_data[23:0], st_data[31:24]};
      2'd2:    rot_data = {st_data[15:0], st_data[31:16]};
      2'd3:    rot_data = {st_data[7:0],  st_data[31:8]};
      default: rot_data = st_data;
    endcase
  end

`ifdef MISALIGN_SPLIT_EN
  assign reject = (st_size == 2'b11);
`else
  // A word-crossing store shows up as a nonzero upper nibble. A halfword at
  // offset 1 stays inside the word but is still misaligned, so it is tested
  // separately.
  assign reject = (st_size == 2'b11) ||
                  (lanes8[7:4] != 4'b0000) ||
                  ((st_size == SIZE_HALF) && off[0]);
`endif

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    hi_be_d     = hi_be_q;
`endif

    case (state_q)
      IDLE: begin
        if (st_valid) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d     = BEAT1;
            mem_req_d   = 1'b1;
            mem_addr_d  = {st_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = rot_data;
            mem_be_d    = lanes8[3:0];
`ifdef MISALIGN_SPLIT_EN
            hi_be_d     = lanes8[7:4];
`endif
          end
        end
      end

      BEAT1: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
`ifdef MISALIGN_SPLIT_EN
          // Move straight to the second word. mem_req stays high, so there is
          // no gap between the two beats.
          if (hi_be_q != 4'b0000) begin
            state_d    = BEAT2;
            mem_req_d  = 1'b1;
            done_d     = 1'b0;
            mem_addr_d = mem_addr_q + ADDR_W'(4);
            mem_be_d   = hi_be_q;
          end
`endif
        end
      end

`ifdef MISALIGN_SPLIT_EN
      BEAT2: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
        end
      end
`endif

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      hi_be_q     <= 4'b0000;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef MISALIGN_SPLIT_EN
      hi_be_q     <= hi_be_d;
`endif
    end
  end

  assign st_ready    = (state_q == IDLE);
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_store_lane_packer.sv
// -----------------------------------------------------------------------------
// tb_store_lane_packer
//
// Directed bench for store_lane_packer. It covers the reset state, SB/SH/SW
// lane placement, a wait-stated ack, word-crossing stores (split or rejected,
// depending on MISALIGN_SPLIT_EN), address wrap, the reserved size,
// back-to-back stores on the done cycle, and reset in the middle of a store.
// Inputs change 1 time unit after a rising edge and outputs are sampled at the
// same point.
// -----------------------------------------------------------------------------
module tb_store_lane_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        err;
  logic [1:0]  dbg_state;

  int passed = 0;
  int total  = 0;

  store_lane_packer #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_size    (st_size),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .done       (done),
    .err        (err),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one store for exactly one accept edge, then scramble the inputs.
  // This shows that only the values captured at the accept edge are used.
  task automatic start(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1;
    st_size  = size;
    st_addr  = addr;
    st_data  = data;
    tick();
    st_valid = 1'b0;
    st_size  = 2'b11;
    st_addr  = 32'hFFFF_FFFF;
    st_data  = 32'h5A5A_5A5A;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata);
    check({tag, "_req"},   {31'b0, mem_req}, 32'd1);
    check({tag, "_addr"},  mem_addr, addr);
    check({tag, "_be"},    {28'b0, mem_be}, {28'b0, be});
    check({tag, "_wdata"}, mem_wdata, wdata);
    check({tag, "_done"},  {31'b0, done}, 32'd0);
  endtask

  task automatic ack_and_finish(input string tag);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check({tag, "_done"},  {31'b0, done}, 32'd1);
    check({tag, "_err"},   {31'b0, err}, 32'd0);
    check({tag, "_req0"},  {31'b0, mem_req}, 32'd0);
    check({tag, "_ready"}, {31'b0, st_ready}, 32'd1);
  endtask

  task automatic check_reject(input string tag);
    check({tag, "_err"},   {31'b0, err}, 32'd1);
    check({tag, "_done"},  {31'b0, done}, 32'd0);
    check({tag, "_req"},   {31'b0, mem_req}, 32'd0);
    check({tag, "_ready"}, {31'b0, st_ready}, 32'd1);
    tick();
    check({tag, "_err0"},  {31'b0, err}, 32'd0);
    check({tag, "_req0"},  {31'b0, mem_req}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    st_valid = 1'b0;
    st_size  = 2'b00;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    mem_ack  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_req",   {31'b0, mem_req}, 32'd0);
    check("rst_addr",  mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_be",    {28'b0, mem_be}, 32'd0);
    check("rst_done",  {31'b0, done}, 32'd0);
    check("rst_err",   {31'b0, err}, 32'd0);
    check("rst_ready", {31'b0, st_ready}, 32'd1);
    check("rst_state", {30'b0, dbg_state}, 32'd0);

    // mem_ack while idle has no effect
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_done", {31'b0, done}, 32'd0);
    check("idle_ack_req",  {31'b0, mem_req}, 32'd0);

    // SB to 0x1003: lane 3, done 2 cycles after accept
    start(2'b00, 32'h0000_1003, 32'h0000_00A5);
    check_beat("sb", 32'h0000_1000, 4'b1000, 32'hA500_0000);
    check("sb_ready", {31'b0, st_ready}, 32'd0);
    ack_and_finish("sb");
    tick();
    check("sb_done_pulse", {31'b0, done}, 32'd0);

    // SH to 0x2002 with ack held off for 3 cycles
    start(2'b01, 32'h0000_2002, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      check_beat("sh_wait", 32'h0000_2000, 4'b1100, 32'hBEEF_DEAD);
      tick();
    end
    check_beat("sh", 32'h0000_2000, 4'b1100, 32'hBEEF_DEAD);
    ack_and_finish("sh");
    tick();

`ifdef MISALIGN_SPLIT_EN
    // SH at offset 1 is a single beat within the word
    start(2'b01, 32'h0000_2401, 32'h0000_1234);
    check_beat("sh1", 32'h0000_2400, 4'b0110, 32'h0012_3400);
    ack_and_finish("sh1");
    tick();

    // SW to 0x3001 is split into two beats with a single done
    start(2'b10, 32'h0000_3001, 32'h1122_3344);
    check_beat("sw_b1", 32'h0000_3000, 4'b1110, 32'h2233_4411);
    mem_ack = 1'b1;
    tick();
    check_beat("sw_b2", 32'h0000_3004, 4'b0001, 32'h2233_4411);
    check("sw_b2_state", {30'b0, dbg_state}, 32'd2);
    ack_and_finish("sw");
    tick();
    check("sw_single_done", {31'b0, done}, 32'd0);

    // SW to 0xFFFFFFFE: the second beat wraps to address 0
    start(2'b10, 32'hFFFF_FFFE, 32'hAABB_CCDD);
    check_beat("wrap_b1", 32'hFFFF_FFFC, 4'b1100, 32'hCCDD_AABB);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_beat("wrap_b2", 32'h0000_0000, 4'b0011, 32'hCCDD_AABB);
    ack_and_finish("wrap");
    tick();
`else
    // A misaligned SH at offset 1 is rejected
    start(2'b01, 32'h0000_2401, 32'h0000_1234);
    check_reject("sh1_rej");

    // SW to 0x3001 is rejected without touching memory
    start(2'b10, 32'h0000_3001, 32'h1122_3344);
    check_reject("sw_rej");

    // SW to 0xFFFFFFFE is rejected
    start(2'b10, 32'hFFFF_FFFE, 32'hAABB_CCDD);
    check_reject("wrap_rej");
`endif

    // A reserved size is always rejected
    start(2'b11, 32'h0000_4000, 32'h0123_4567);
    check_reject("rsv");

    // Back-to-back: a new SW is accepted in the done cycle
    start(2'b10, 32'h0000_5000, 32'hCAFE_F00D);
    check_beat("b2b_1", 32'h0000_5000, 4'b1111, 32'hCAFE_F00D);
    ack_and_finish("b2b_1");
    st_valid = 1'b1;
    st_size  = 2'b10;
    st_addr  = 32'h0000_6004;
    st_data  = 32'h0BAD_BEEF;
    tick();
    st_valid = 1'b0;
    check_beat("b2b_2", 32'h0000_6004, 4'b1111, 32'h0BAD_BEEF);
    ack_and_finish("b2b_2");
    tick();

    // Reset during BEAT1 with mem_ack low
    start(2'b00, 32'h0000_7000, 32'h0000_0077);
    check("mid_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_req0",  {31'b0, mem_req}, 32'd0);
    check("mid_ready", {31'b0, st_ready}, 32'd1);
    check("mid_done",  {31'b0, done}, 32'd0);
    check("mid_err",   {31'b0, err}, 32'd0);
    tick();
    check("mid_done2", {31'b0, done}, 32'd0);
    check("mid_err2",  {31'b0, err}, 32'd0);
    check("mid_req2",  {31'b0, mem_req}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/store_lane_packer.md
# store_lane_packer

Store-path narrowing unit for the MP3 multi-cycle MIPS core: the write-side counterpart of the load-path sign/zero extension. Takes a 32-bit register value plus a store size (SB/SH/SW) and byte address from the datapath, places the valid bytes onto the correct lanes of a 32-bit little-endian data memory word, generates byte enables, and drives a request/acknowledge write handshake to data memory. Misaligned stores are either rejected or split into two aligned word writes (see Configuration).

## Interface
- ADDR_W, 32, width of byte address and memory address
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- st_valid  in  1  store request from datapath
- st_ready  out  1  unit idle, can accept a store
- st_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- st_addr  in  ADDR_W  byte address
- st_data  in  32  register value; low byte/halfword used for SB/SH
- mem_req  out  1  write request to data memory
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] always 00)
- mem_wdata  out  32  lane-placed write data
- mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
- mem_ack  in  1  memory accepted current write
- done  out  1  one-cycle pulse, store completed
- err  out  1  one-cycle pulse, store rejected

## Operation
- States: IDLE, BEAT1, BEAT2. st_ready = (state == IDLE).
- Accept on st_valid & st_ready at a rising edge; st_size/st_addr/st_data captured; later input changes ignored.
- off = st_addr[1:0]; mask = 0001 (byte), 0011 (half), 1111 (word); lanes8 = {4'b0, mask} << off (8 bits).
- mem_wdata = st_data rotated left by 8*off, identical on both beats.
- BEAT1: mem_addr = {st_addr[ADDR_W-1:2], 2'b00}, mem_be = lanes8[3:0].
- BEAT2: mem_addr = BEAT1 address + 4 (wraps 0xFFFFFFFC -> 0x00000000), mem_be = lanes8[7:4].
- Aligned store (lanes8[7:4] == 0): IDLE -> BEAT1 -> IDLE.
- Word-crossing store (lanes8[7:4] != 0): see Configuration.
- st_size == 11: rejected regardless of configuration; err pulse, no memory access.
- mem_req, mem_addr, mem_wdata, mem_be held stable in BEAT1/BEAT2 until mem_ack sampled high; mem_ack ignored while mem_req low.
- Reset values: mem_req 0, mem_addr 0, mem_wdata 0, mem_be 0, done 0, err 0, state IDLE (st_ready 1).
- Reset mid-operation: mem_req drops at the reset edge, state IDLE, no done/err for the aborted store.

## Timing
- Accept at edge 0 -> mem_req high from cycle 1.
- mem_ack high at edge N during final beat -> state IDLE, done = 1 for exactly the cycle after edge N.
- Minimum aligned store latency: accept to done = 2 cycles; split store: 3 cycles with zero-wait ack.
- done cycle is IDLE: st_ready = 1, new store accepted in that cycle (back-to-back, one idle cycle per store).
- BEAT1 -> BEAT2 on ack with no gap: mem_req stays high, address/be change at the ack edge.
- Rejected store: err = 1 the cycle after accept, state stays IDLE, mem_req never asserted.
- done and err never high together.

## Configuration
- MISALIGN_SPLIT_EN defined: word-crossing stores execute BEAT1 then BEAT2; single done after BEAT2 ack. Within-word misaligned halfwords (off = 1) are a single beat, mem_be = 0110.
- MISALIGN_SPLIT_EN undefined: any misaligned halfword (off[0] = 1) or word (off != 0) is rejected with err; no BEAT2 state logic is built.

## Test plan
- SB st_addr 0x1003, st_data 0x000000A5 -> one beat, mem_addr 0x1000, mem_be 1000, mem_wdata[31:24] = 0xA5, done 2 cycles after accept.
- SH st_addr 0x2002, st_data 0xDEADBEEF -> mem_addr 0x2000, mem_be 1100, mem_wdata[31:16] = 0xBEEF; ack held off 3 cycles -> outputs stable, done cycle after ack.
- SW st_addr 0x3001, st_data 0x11223344: with macro -> beat 1 addr 0x3000 be 1110, beat 2 addr 0x3004 be 0001, mem_wdata 0x22334411 both beats, one done; without macro -> err pulse, mem_req stays 0.
- SW st_addr 0xFFFFFFFE, split build -> beat 2 mem_addr 0x00000000, be 0011.
- st_size 11 -> err one cycle after accept, no mem_req; back-to-back SW accepted on done cycle -> second mem_req the next cycle.
- reset asserted during BEAT1 with mem_ack low -> mem_req 0, st_ready 1 next cycle, no done/err.
